// File: rtl/hazard_unit.sv
// LEGv8 5-stage pipeline hazard control: load-use / CBZ / B.cond stalls,
// IF/ID flush on taken branches, and saturating stall/flush event counters.
module hazard_unit #(
  parameter int         CNTW = 16,
  parameter logic [4:0] ZR   = 5'd31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      IFIDrn,
  input  logic [4:0]      IFIDrm,
  input  logic            useRn,
  input  logic            useRm,
  input  logic            isCBZ,
  input  logic            isBcond,
  input  logic            brTaken,
  input  logic [4:0]      IDEXrd,
  input  logic            IDEXregWrite,
  input  logic            IDEXmemRead,
  input  logic            IDEXsetFlags,
  output logic            pcWrite,
  output logic            ifidWrite,
  output logic            idexBubble,
  output logic            ifidFlush,
  output logic [CNTW-1:0] stallCount,
  output logic [CNTW-1:0] flushCount
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, next_state;

  logic dep_rn, dep_rm, dep;
  logic h_load, h_cbz_alu, h_cbz_load, h_flag;
  logic stall, flush;

  // XZR reads as zero and is never really written, so it can't create a dependency.
  assign dep_rn = useRn & (IFIDrn != ZR) & (IFIDrn == IDEXrd) & IDEXregWrite;
  assign dep_rm = useRm & (IFIDrm != ZR) & (IFIDrm == IDEXrd) & IDEXregWrite;
  assign dep    = dep_rn | dep_rm;

  assign h_load     = IDEXmemRead & dep;
  assign h_cbz_alu  = isCBZ & dep & ~IDEXmemRead;
  assign h_cbz_load = isCBZ & dep & IDEXmemRead;
  assign h_flag     = isBcond & IDEXsetFlags;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = RUN;
    stall      = 1'b0;
    unique case (state)
      RUN: begin
        stall = h_load | h_cbz_alu | h_cbz_load | h_flag;
        if (h_cbz_load) next_state = HOLD;
      end
      HOLD: begin
        stall      = 1'b1;
        next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

  // A stalled branch has not resolved yet, so its brTaken must not flush.
  assign flush = brTaken & ~stall;

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexBubble = 1'b0;
    ifidFlush  = 1'b0;
    if (reset || stall) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end else begin
      ifidFlush = flush;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stall && (stallCount != '1)) stallCount <= stallCount + 1'b1;
      if (flush && (flushCount != '1)) flushCount <= flushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, hand-written
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IFIDrn, IFIDrm, IDEXrd;
  logic        useRn, useRm, isCBZ, isBcond, brTaken;
  logic        IDEXregWrite, IDEXmemRead, IDEXsetFlags;

  logic        pcWrite, ifidWrite, idexBubble, ifidFlush;
  logic [15:0] stallCount, flushCount;
  logic        s_pcWrite, s_ifidWrite, s_idexBubble, s_ifidFlush;
  logic [3:0]  s_stallCount, s_flushCount;

  always #5 clk = ~clk;

  hazard_unit #(.CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .IFIDrn(IFIDrn), .IFIDrm(IFIDrm), .useRn(useRn), .useRm(useRm),
    .isCBZ(isCBZ), .isBcond(isBcond), .brTaken(brTaken),
    .IDEXrd(IDEXrd), .IDEXregWrite(IDEXregWrite), .IDEXmemRead(IDEXmemRead),
    .IDEXsetFlags(IDEXsetFlags),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexBubble(idexBubble),
    .ifidFlush(ifidFlush), .stallCount(stallCount), .flushCount(flushCount)
  );

  hazard_unit #(.CNTW(4)) dut_sat (
    .clk(clk), .reset(reset),
    .IFIDrn(IFIDrn), .IFIDrm(IFIDrm), .useRn(useRn), .useRm(useRm),
    .isCBZ(isCBZ), .isBcond(isBcond), .brTaken(brTaken),
    .IDEXrd(IDEXrd), .IDEXregWrite(IDEXregWrite), .IDEXmemRead(IDEXmemRead),
    .IDEXsetFlags(IDEXsetFlags),
    .pcWrite(s_pcWrite), .ifidWrite(s_ifidWrite), .idexBubble(s_idexBubble),
    .ifidFlush(s_ifidFlush), .stallCount(s_stallCount), .flushCount(s_flushCount)
  );

  typedef struct {
    string      name;
    logic [4:0] rn, rm, rd;
    logic       urn, urm, cbz, bcond, br, rw, mr, sf;
    logic [3:0] exp;  // {pcWrite, ifidWrite, idexBubble, ifidFlush}
  } vec_t;

  localparam logic [3:0] GO = 4'b1100, STALL = 4'b0010, FLUSH = 4'b1101;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: outstanding forced-stall cycles plus plain event totals.
  int hold_left = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input string name, input int rn, input int rm, input bit urn,
                              input bit urm, input bit cbz, input bit bcond, input bit br,
                              input int rd, input bit rw, input bit mr, input bit sf,
                              input logic [3:0] exp);
    vec_t v;
    v.name = name; v.rn = rn[4:0]; v.rm = rm[4:0]; v.urn = urn; v.urm = urm;
    v.cbz = cbz; v.bcond = bcond; v.br = br; v.rd = rd[4:0];
    v.rw = rw; v.mr = mr; v.sf = sf; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    IFIDrn = v.rn; IFIDrm = v.rm; useRn = v.urn; useRm = v.urm;
    isCBZ = v.cbz; isBcond = v.bcond; brTaken = v.br;
    IDEXrd = v.rd; IDEXregWrite = v.rw; IDEXmemRead = v.mr; IDEXsetFlags = v.sf;
  endtask

  task automatic drive_idle();
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, GO));
  endtask

  function automatic bit reads(input logic u, input logic [4:0] r);
    return u && (r != 5'd31) && (r == IDEXrd) && IDEXregWrite;
  endfunction

  function automatic logic [3:0] model_out();
    bit d, stl;
    d = reads(useRn, IFIDrn) || reads(useRm, IFIDrm);
    if (hold_left > 0) stl = 1'b1;
    else stl = (IDEXmemRead && d) || (isCBZ && d) || (isBcond && IDEXsetFlags);
    if (stl) return STALL;
    return brTaken ? FLUSH : GO;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_counts(input string name);
    check({name, " stallCount"}, 32'(stallCount), sat(m_stalls, 65535));
    check({name, " flushCount"}, 32'(flushCount), sat(m_flushes, 65535));
    check({name, " sat stallCount"}, 32'(s_stallCount), sat(m_stalls, 15));
    check({name, " sat flushCount"}, 32'(s_flushCount), sat(m_flushes, 15));
  endtask

  // One pipeline cycle: compare mid-cycle, advance the model, step past the edge.
  task automatic cycle(input string name, input bit use_exp, input logic [3:0] exp);
    logic [3:0] m;
    bit d;
    m = model_out();
    @(negedge clk);
    check({name, " outs"}, 32'({pcWrite, ifidWrite, idexBubble, ifidFlush}), use_exp ? exp : m);
    check({name, " sat outs"}, 32'({s_pcWrite, s_ifidWrite, s_idexBubble, s_ifidFlush}),
          use_exp ? exp : m);
    check_counts(name);
    d = reads(useRn, IFIDrn) || reads(useRm, IFIDrm);
    if (m == STALL) m_stalls++;
    if (m == FLUSH) m_flushes++;
    if (hold_left > 0) hold_left = 0;
    else if (isCBZ && d && IDEXmemRead) hold_left = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    brTaken = 1'b1;
    #1;
    check("reset outs", 32'({pcWrite, ifidWrite, idexBubble, ifidFlush}), STALL);
    check("reset stallCount", 32'(stallCount), 0);
    check("reset flushCount", 32'(flushCount), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    drive_idle();
    hold_left = 0; m_stalls = 0; m_flushes = 0;
  endtask

  vec_t tbl[$];

  initial begin
    reset = 1'b1;
    drive_idle();

    tbl.push_back(mk("idle",           0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, GO));
    tbl.push_back(mk("load-use rn",    2,  0, 1, 0, 0, 0, 0,  2, 1, 1, 0, STALL));
    tbl.push_back(mk("after load",     2,  0, 1, 0, 0, 0, 0,  0, 0, 0, 0, GO));
    tbl.push_back(mk("xzr no dep",    31,  0, 1, 0, 0, 0, 0, 31, 1, 1, 0, GO));
    tbl.push_back(mk("no regwrite",    2,  0, 1, 0, 0, 0, 0,  2, 0, 1, 0, GO));
    tbl.push_back(mk("load-use rm",    0,  7, 0, 1, 0, 0, 0,  7, 1, 1, 0, STALL));
    tbl.push_back(mk("rm unused",      0,  7, 0, 0, 0, 0, 0,  7, 1, 1, 0, GO));
    tbl.push_back(mk("alu fwd ok",     3,  0, 1, 0, 0, 0, 0,  3, 1, 0, 0, GO));
    tbl.push_back(mk("cbz after alu",  0,  4, 0, 1, 1, 0, 0,  4, 1, 0, 0, STALL));
    tbl.push_back(mk("bcond flags br", 0,  0, 0, 0, 0, 1, 1,  0, 0, 0, 1, STALL));
    tbl.push_back(mk("bcond taken",    0,  0, 0, 0, 0, 1, 1,  0, 0, 0, 0, FLUSH));
    tbl.push_back(mk("branch taken",   0,  0, 0, 0, 0, 0, 1,  0, 0, 0, 0, FLUSH));
    tbl.push_back(mk("cbz after load", 0,  5, 0, 1, 1, 0, 1,  5, 1, 1, 0, STALL));
    tbl.push_back(mk("hold ignores",   0,  0, 0, 0, 0, 0, 1,  9, 0, 0, 0, STALL));
    tbl.push_back(mk("after hold",     0,  0, 0, 0, 0, 0, 0,  0, 0, 0, 0, GO));
    tbl.push_back(mk("multi class",    6,  6, 1, 1, 1, 1, 1,  6, 1, 0, 1, STALL));
    tbl.push_back(mk("flags no br",    0,  0, 0, 0, 0, 1, 0,  0, 0, 0, 1, STALL));

    do_reset();
    foreach (tbl[i]) begin
      drive(tbl[i]);
      cycle(tbl[i].name, 1'b1, tbl[i].exp);
    end

    // LDUR X2 then ADD X3,X2,X4: exactly one stall cycle.
    do_reset();
    drive(mk("ldur-add", 2, 4, 1, 1, 0, 0, 0, 2, 1, 1, 0, STALL));
    cycle("ldur-add c1", 1'b1, STALL);
    drive(mk("ldur-add", 2, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, GO));
    cycle("ldur-add c2", 1'b1, GO);
    check("ldur-add stallCount", 32'(stallCount), 1);

    // LDUR X5 then CBZ X5: two stall cycles even after EX changes.
    do_reset();
    drive(mk("ldur-cbz", 0, 5, 0, 1, 1, 0, 0, 5, 1, 1, 0, STALL));
    cycle("ldur-cbz c1", 1'b1, STALL);
    drive(mk("ldur-cbz", 0, 5, 0, 1, 1, 0, 0, 12, 1, 0, 1, STALL));
    cycle("ldur-cbz c2", 1'b1, STALL);
    drive(mk("ldur-cbz", 0, 5, 0, 1, 1, 0, 0, 12, 1, 0, 1, GO));
    cycle("ldur-cbz c3", 1'b1, GO);
    check("ldur-cbz stallCount", 32'(stallCount), 2);

    // SUBS then B.cond taken: stall without flush, then flush.
    do_reset();
    drive(mk("subs-bcond", 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 1, STALL));
    cycle("subs-bcond c1", 1'b1, STALL);
    drive(mk("subs-bcond", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, FLUSH));
    cycle("subs-bcond c2", 1'b1, FLUSH);
    check("subs-bcond flushCount", 32'(flushCount), 1);

    // Long load-use stall run saturates the narrow counter at 15.
    do_reset();
    drive(mk("long stall", 8, 0, 1, 0, 0, 0, 0, 8, 1, 1, 0, STALL));
    for (int i = 0; i < 19; i++) cycle("long stall", 1'b0, 4'b0);
    check("saturated stallCount", 32'(s_stallCount), 15);
    check("wide stallCount", 32'(stallCount), 19);

    // Asynchronous reset in the middle of HOLD.
    drive(mk("enter hold", 0, 3, 0, 1, 1, 0, 0, 3, 1, 1, 0, STALL));
    cycle("enter hold", 1'b1, STALL);
    drive_idle();
    #1;
    check("in hold outs", 32'({pcWrite, ifidWrite, idexBubble, ifidFlush}), STALL);
    reset = 1'b1;
    #1;
    check("mid-hold reset outs", 32'({pcWrite, ifidWrite, idexBubble, ifidFlush}), STALL);
    check("mid-hold reset stallCount", 32'(stallCount), 0);
    check("mid-hold reset sat stallCount", 32'(s_stallCount), 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    hold_left = 0; m_stalls = 0; m_flushes = 0;
    cycle("after mid-hold reset", 1'b1, GO);

    // Random traffic against the model; small register range forces collisions.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 4); IFIDrn = (r == 4) ? 5'd31 : 5'(r);
      r = $urandom_range(0, 4); IFIDrm = (r == 4) ? 5'd31 : 5'(r);
      r = $urandom_range(0, 4); IDEXrd = (r == 4) ? 5'd31 : 5'(r);
      useRn = 1'($urandom); useRm = 1'($urandom);
      isCBZ = ($urandom_range(0, 3) == 0); isBcond = ($urandom_range(0, 3) == 0);
      brTaken = 1'($urandom);
      IDEXregWrite = ($urandom_range(0, 3) != 0);
      IDEXmemRead = 1'($urandom); IDEXsetFlags = 1'($urandom);
      cycle("random", 1'b0, 4'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard-control block for the 5-stage LEGv8 pipeline. The forwarding path resolves operands after they are produced; this block handles the cases forwarding cannot cover.
- When an ID-stage consumer needs a result that does not exist yet, it stalls the front end (PC, IF/ID) and injects bubbles into ID/EX.
- It flushes IF/ID on taken branches and keeps saturating stall/flush event counters for performance debug.
- Sits beside the decoder, between the IF/ID and ID/EX pipeline registers.

Parameters:
- CNTW, 16, width of the stallCount and flushCount saturating counters.
- ZR, 31, register index of XZR; it never creates a dependency.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- IFIDrn  input  5  Rn field of the instruction in ID.
- IFIDrm  input  5  Rm (or Rt for STUR/CBZ) field of the instruction in ID.
- useRn  input  1  ID instruction reads Rn.
- useRm  input  1  ID instruction reads Rm/Rt.
- isCBZ  input  1  ID instruction is CBZ (register compared in ID).
- isBcond  input  1  ID instruction is B.cond (flags consumed in ID).
- brTaken  input  1  ID branch resolved taken (valid only when the unit is not stalling).
- IDEXrd  input  5  destination register of the EX-stage instruction.
- IDEXregWrite  input  1  EX instruction writes a register.
- IDEXmemRead  input  1  EX instruction is LDUR.
- IDEXsetFlags  input  1  EX instruction sets NZCV.
- pcWrite  output  1  PC load enable (0 = hold).
- ifidWrite  output  1  IF/ID load enable (0 = hold).
- idexBubble  output  1  zero the ID/EX control bits this cycle.
- ifidFlush  output  1  clear the IF/ID instruction to NOP on the next edge.
- stallCount  output  CNTW  cycles with stall asserted, saturating.
- flushCount  output  CNTW  flushes issued, saturating.

Behaviour:
- Definitions (combinational):
  - depRn = useRn & (IFIDrn != ZR) & (IFIDrn == IDEXrd) & IDEXregWrite.
  - depRm = the same expression using useRm and IFIDrm.
  - dep = depRn | depRm.
- Hazard classes, evaluated in state RUN:
  - H_LOAD: IDEXmemRead & dep. One-cycle stall.
  - H_CBZ_ALU: isCBZ & dep & ~IDEXmemRead. One-cycle stall.
  - H_CBZ_LOAD: isCBZ & dep & IDEXmemRead. Two-cycle stall.
  - H_FLAG: isBcond & IDEXsetFlags. One-cycle stall.
- stall = (state == HOLD) | any hazard class active in RUN.
- When stall is 1: pcWrite=0, ifidWrite=0, idexBubble=1.
- When stall is 0: pcWrite=1, ifidWrite=1, idexBubble=0.
- ifidFlush = brTaken & ~stall. A stall suppresses the flush because the branch decision is not yet valid.
- State machine (2 states), registered:
  - RUN → HOLD when H_CBZ_LOAD is active. The next cycle stalls unconditionally, while the load sits in MEM.
  - RUN → RUN in every other case. One-cycle hazards simply re-evaluate the next cycle: the bubble has advanced, so the producer is no longer in EX.
  - HOLD → RUN unconditionally after one cycle. In HOLD the hazard inputs are ignored; stall is forced to 1 and ifidFlush to 0.
- Counters, on the clock edge:
  - stallCount increments when stall is 1; flushCount increments when ifidFlush is 1.
  - Both saturate at all-ones with no wrap.
- Simultaneous events:
  - Several hazard classes active at once still give a single stall cycle, except that H_CBZ_LOAD always enters HOLD.
  - A stall and brTaken in the same cycle produce a stall with no flush.
- Latency: stall and flush outputs are combinational from the inputs and state, in the same cycle.
- Reset (asynchronous, active-high):
  - state = RUN; stallCount = 0; flushCount = 0.
  - While reset is high, the outputs are forced to pcWrite=0, ifidWrite=0, idexBubble=1, ifidFlush=0.
  - Counters do not increment while reset is high.
  - Reset asserted in HOLD returns the unit to RUN immediately. After deassertion, behaviour is exactly as from a clean start.

Test Plan:
- LDUR X2 in EX (IDEXrd=2, memRead=1, regWrite=1); ADD X3,X2,X4 in ID (useRn=1, IFIDrn=2) → one cycle of pcWrite=0/ifidWrite=0/idexBubble=1, then outputs 1/1/0; stallCount=1.
- Same LDUR but IFIDrn=31, IDEXrd=31 → no stall; stallCount stays 0.
- LDUR X5 in EX, CBZ X5 in ID (isCBZ=1, useRm=1, IFIDrm=5) → stall for exactly 2 cycles; in the second cycle EX inputs are changed to unrelated values and the stall still holds; stallCount=2.
- SUBS in EX (setFlags=1), B.cond in ID with brTaken=1 → cycle 1: stall=1, ifidFlush=0; cycle 2 (no hazard, brTaken=1): ifidFlush=1, pcWrite=1; flushCount=1.
- Counter preload via a long stall run: hold H_LOAD inputs for 2^CNTW+3 cycles (use CNTW=4) → stallCount saturates at 15 and does not wrap.
- Assert reset asynchronously mid-HOLD (between edges) → outputs immediately become 0/0/1/0 and counters read 0. After deassertion with no hazard inputs, the first cycle gives pcWrite=1 and state RUN.
